// File: rtl/spi_bus_arbiter_if.sv
// spi_bus_arbiter_if
//   Command-side bus between the four on-chip requesters and the SPI
//   bus arbiter. All four requester lanes are carried side by side; lane i
//   uses bit i of the 4-bit vectors and byte [8i+7:8i] of the 32-bit ones.
//
//   Handshake: a requester raises req[i] (level) with cmd_rw/cmd_addr/
//   cmd_wdata for lane i stable. The arbiter answers with a one-cycle
//   gnt[i] pulse in the cycle it latches lane i's command; from that
//   point cmd_* of lane i may change and req[i] may drop. When the frame
//   has finished, done[i] pulses for one cycle and rdata carries the read
//   byte (held until the next done). busy covers the gnt cycle through the
//   done cycle. A req still high after done simply competes again.
//
//   Ports (modport slave = arbiter view):
//     req       in   4   per-lane level request
//     cmd_rw    in   4   per-lane R/W, 1 = write
//     cmd_addr  in  32   per-lane address bytes
//     cmd_wdata in  32   per-lane write data bytes
//     gnt       out  4   one-hot command-latched pulse
//     done      out  4   one-hot frame-complete pulse
//     rdata     out  8   last read byte
//     busy      out  1   arbiter owns the SPI bus
interface spi_bus_arbiter_if;
  logic [3:0]  req;
  logic [3:0]  cmd_rw;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  gnt;
  logic [3:0]  done;
  logic [7:0]  rdata;
  logic        busy;

  modport master (
    output req, cmd_rw, cmd_addr, cmd_wdata,
    input  gnt, done, rdata, busy
  );

  modport slave (
    input  req, cmd_rw, cmd_addr, cmd_wdata,
    output gnt, done, rdata, busy
  );
endinterface

// File: rtl/spi_bus_arbiter.sv
// spi_bus_arbiter
//   Shares one SPI master bus among four requesters. Each granted command
//   is sent as a 17-bit frame, MSB first: R/W (1 = write), 8 address bits,
//   8 data bits. SPI mode 0: scl idles low, mosi changes at the start of a
//   bit period, miso is sampled on scl rising edges of the data phase of
//   read frames and returned on rdata.
//
//   Optional build macro SPI_ARB_FIXED_PRIO_EN: when defined, arbitration
//   is fixed priority (lane 0 highest) and the round-robin pointer does not
//   exist. Timing is identical in both builds.
//
//   Parameters:
//     CLK_DIV     clk cycles per scl half-period (1..255)
//     FRAME_BITS  bits per frame, fixed at 17
//
//   Ports:
//     clk        in   system clock, rising edge
//     rst_n      in   asynchronous active-low reset
//     bus        slave modport of spi_bus_arbiter_if (req/cmd/gnt/done...)
//     scl        out  SPI clock, idles low
//     mosi       out  SPI data out
//     miso       in   SPI data in
//     ss1..ss4   out  slave selects, active low, lane i -> ss(i+1)
//     state_dbg  out  current FSM state encoding
module spi_bus_arbiter #(
  parameter int CLK_DIV    = 2,
  parameter int FRAME_BITS = 17
) (
  input  logic             clk,
  input  logic             rst_n,
  spi_bus_arbiter_if.slave bus,
  output logic             scl,
  output logic             mosi,
  input  logic             miso,
  output logic             ss1,
  output logic             ss2,
  output logic             ss3,
  output logic             ss4,
  output logic [2:0]       state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_SHIFT = 3'd2,
    S_HOLD  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [7:0] DIV_LAST   = 8'(CLK_DIV - 1);
  localparam logic [4:0] BIT_LAST   = 5'(FRAME_BITS - 1);
  // First data-phase bit index (R/W + 8 address bits precede it).
  localparam logic [4:0] DATA_FIRST = 5'(FRAME_BITS - 8);

  state_t                state, state_n;
  logic [7:0]            hcnt, hcnt_n;      // clk count within a half-period
  logic [4:0]            bitcnt, bitcnt_n;  // 0..16, saturates, never wraps
  logic [FRAME_BITS-1:0] sreg, sreg_n;      // outgoing frame, MSB on mosi
  logic [7:0]            rshift, rshift_n;  // incoming read byte
  logic [7:0]            rdata_q, rdata_n;
  logic [1:0]            win, win_n;        // lane owning the current frame
  logic                  is_read, is_read_n;
  logic                  scl_q, scl_n;
  logic [3:0]            ss_q, ss_n;
  logic [3:0]            done_q, done_n;
  logic [3:0]            grant;
  logic [3:0]            gnt_o;
  logic                  take;
  logic [1:0]            pick;

  // ---------------------------------------------------------------------
  // Winner selection. Only consulted when take is high.
  // ---------------------------------------------------------------------
`ifdef SPI_ARB_FIXED_PRIO_EN
  // Lowest index wins; scanning downward lets the lowest set bit land last.
  always_comb begin
    pick = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (bus.req[k]) pick = 2'(k);
    end
  end
`else
  logic [1:0] rr_ptr;  // last granted lane

  // Search rr_ptr+1, +2, +3, +4 (= rr_ptr itself) with 2-bit wrap; the
  // descending scan leaves the nearest candidate after rr_ptr in pick.
  always_comb begin
    pick = rr_ptr;
    for (int k = 4; k >= 1; k--) begin
      if (bus.req[rr_ptr + 2'(k)]) pick = rr_ptr + 2'(k);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= 2'd3;
    end else if (take) begin
      rr_ptr <= pick;
    end
  end
`endif

  // ---------------------------------------------------------------------
  // Next-state and datapath logic.
  // ---------------------------------------------------------------------
  always_comb begin
    state_n   = state;
    hcnt_n    = hcnt;
    bitcnt_n  = bitcnt;
    sreg_n    = sreg;
    rshift_n  = rshift;
    rdata_n   = rdata_q;
    win_n     = win;
    is_read_n = is_read;
    scl_n     = scl_q;
    done_n    = 4'h0;
    grant     = 4'h0;
    take      = 1'b0;
    ss_n      = 4'hF;

    case (state)
      S_IDLE: begin
        take = |bus.req;
      end

      S_SETUP: begin
        // mosi already shows the R/W bit; scl stays low.
        if (hcnt == DIV_LAST) begin
          hcnt_n   = 8'd0;
          bitcnt_n = 5'd0;
          state_n  = S_SHIFT;
        end else begin
          hcnt_n = hcnt + 8'd1;
        end
      end

      S_SHIFT: begin
        if (hcnt == DIV_LAST) begin
          hcnt_n = 8'd0;
          if (!scl_q) begin
            // End of low half: scl rises. miso is taken here so the value
            // the slave set up during the low half is the one captured.
            scl_n = 1'b1;
            if (is_read && (bitcnt >= DATA_FIRST)) begin
              rshift_n = {rshift[6:0], miso};
            end
          end else begin
            // End of high half: scl falls and the next bit goes out.
            scl_n = 1'b0;
            if (bitcnt == BIT_LAST) begin
              state_n = S_HOLD;
            end else begin
              bitcnt_n = bitcnt + 5'd1;
              sreg_n   = {sreg[FRAME_BITS-2:0], 1'b0};
            end
          end
        end else begin
          hcnt_n = hcnt + 8'd1;
        end
      end

      S_HOLD: begin
        if (hcnt == DIV_LAST) begin
          hcnt_n       = 8'd0;
          state_n      = S_DONE;
          sreg_n       = '0;
          done_n[win]  = 1'b1;
          if (is_read) rdata_n = rshift;
        end else begin
          hcnt_n = hcnt + 8'd1;
        end
      end

      S_DONE: begin
        // DONE also performs the IDLE evaluation, so a waiting requester
        // is granted here and the select gap between frames is one cycle.
        take = |bus.req;
        if (!take) state_n = S_IDLE;
      end

      default: begin
        state_n = S_IDLE;
      end
    endcase

    if (take) begin
      grant[pick] = 1'b1;
      win_n       = pick;
      state_n     = S_SETUP;
      hcnt_n      = 8'd0;
      scl_n       = 1'b0;
      is_read_n   = ~bus.cmd_rw[pick];
      rshift_n    = 8'h00;
      // Read frames carry zeros in the data phase, whatever cmd_wdata holds.
      sreg_n      = {bus.cmd_rw[pick],
                     bus.cmd_addr[{pick, 3'b000} +: 8],
                     bus.cmd_rw[pick] ? bus.cmd_wdata[{pick, 3'b000} +: 8] : 8'h00};
    end

    // Selects are registered from the next state so they line up exactly
    // with SETUP/SHIFT/HOLD and drop in DONE.
    if (state_n inside {S_SETUP, S_SHIFT, S_HOLD}) begin
      ss_n[win_n] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      hcnt    <= 8'd0;
      bitcnt  <= 5'd0;
      sreg    <= '0;
      rshift  <= 8'h00;
      rdata_q <= 8'h00;
      win     <= 2'd0;
      is_read <= 1'b0;
      scl_q   <= 1'b0;
      ss_q    <= 4'hF;
      done_q  <= 4'h0;
    end else begin
      state   <= state_n;
      hcnt    <= hcnt_n;
      bitcnt  <= bitcnt_n;
      sreg    <= sreg_n;
      rshift  <= rshift_n;
      rdata_q <= rdata_n;
      win     <= win_n;
      is_read <= is_read_n;
      scl_q   <= scl_n;
      ss_q    <= ss_n;
      done_q  <= done_n;
    end
  end

  // ---------------------------------------------------------------------
  // Outputs. gnt is combinational in the evaluation cycle; it is gated
  // with rst_n so nothing is granted while reset is held.
  // ---------------------------------------------------------------------
  assign gnt_o     = rst_n ? grant : 4'h0;
  assign bus.gnt   = gnt_o;
  assign bus.done  = done_q;
  assign bus.rdata = rdata_q;
  assign bus.busy  = (state != S_IDLE) || (|gnt_o);

  assign scl       = scl_q;
  assign mosi      = sreg[FRAME_BITS-1];
  assign ss1       = ss_q[0];
  assign ss2       = ss_q[1];
  assign ss3       = ss_q[2];
  assign ss4       = ss_q[3];
  assign state_dbg = state;

endmodule

// File: tb/tb_spi_bus_arbiter.sv
module tb_spi_bus_arbiter;

  // -------------------------------------------------------------------
  // Clock / reset
  // -------------------------------------------------------------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // -------------------------------------------------------------------
  // DUTs: dut at CLK_DIV=2, dut1 at CLK_DIV=1
  // -------------------------------------------------------------------
  spi_bus_arbiter_if bus ();
  spi_bus_arbiter_if bus1 ();

  logic       scl, mosi, miso, ss1, ss2, ss3, ss4;
  logic [2:0] state_dbg;
  logic       scl1, mosi1, miso1, s1_1, s1_2, s1_3, s1_4;
  logic [2:0] state_dbg1;
  assign miso1 = 1'b0;

  spi_bus_arbiter #(.CLK_DIV(2)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .scl(scl), .mosi(mosi), .miso(miso),
    .ss1(ss1), .ss2(ss2), .ss3(ss3), .ss4(ss4),
    .state_dbg(state_dbg)
  );

  spi_bus_arbiter #(.CLK_DIV(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1),
    .scl(scl1), .mosi(mosi1), .miso(miso1),
    .ss1(s1_1), .ss2(s1_2), .ss3(s1_3), .ss4(s1_4),
    .state_dbg(state_dbg1)
  );

  // -------------------------------------------------------------------
  // Counters and compare helper
  // -------------------------------------------------------------------
  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: timed out waiting (t=%0t)", name, $time);
  endtask

  // -------------------------------------------------------------------
  // Scoreboard queues
  //   exp_q  : {chk_gap[43], lane[42:41], rdata[40:33], frame[32:16],
  //             ss_low_cycles[15:8], gnt_to_done[7:0]}
  //   exp1_q : {lane[42:41], rdata[40:33], frame[32:16], low[15:8], lat[7:0]}
  // -------------------------------------------------------------------
  localparam int W = 44;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp1_q[$];

  function automatic logic [W-1:0] mk(input bit chk_gap, input logic [1:0] lane,
                                      input logic [7:0] rd, input logic [16:0] fr,
                                      input logic [7:0] low, input logic [7:0] lat);
    return {chk_gap, lane, rd, fr, low, lat};
  endfunction

  // -------------------------------------------------------------------
  // Monitor + slave model for dut (CLK_DIV=2)
  // -------------------------------------------------------------------
  logic        prev_scl;
  int          rises, low_cnt, hi_run, gap_obs, t_gnt, sel_obs;
  logic [16:0] frame_obs;
  logic [7:0]  slave_byte = 8'h00;

  always @(negedge clk) begin : monitor
    logic [3:0]   ssv;
    logic [W-1:0] e;
    int           li;
    ssv = {ss4, ss3, ss2, ss1};
    if (!rst_n) begin
      prev_scl  = 1'b0;
      rises     = 0;
      low_cnt   = 0;
      hi_run    = 0;
      gap_obs   = 0;
      t_gnt     = 0;
      sel_obs   = -1;
      frame_obs = '0;
      miso      = 1'b0;
    end else begin
      if (bus.done != 4'h0) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_done: got done=%b with no frame expected", bus.done);
        end else begin
          e = exp_q.pop_front();
          check("done_onehot", 32'(bus.done), 32'(4'b0001 << e[42:41]));
          check("rdata", 32'(bus.rdata), 32'(e[40:33]));
          check("mosi_frame", 32'(frame_obs), 32'(e[32:16]));
          check("ss_low_cycles", low_cnt, 32'(e[15:8]));
          check("gnt_to_done", cyc - t_gnt, 32'(e[7:0]));
          check("ss_select", sel_obs, 32'(e[42:41]));
          if (e[43]) check("ss_gap", gap_obs, 32'd1);
        end
        rises     = 0;
        frame_obs = '0;
        low_cnt   = 0;
        sel_obs   = -1;
      end
      if (bus.gnt != 4'h0) t_gnt = cyc;
      if (ssv != 4'hF) begin
        if (hi_run > 0) gap_obs = hi_run;
        hi_run = 0;
        low_cnt++;
        li = 0;
        for (int i = 0; i < 4; i++) if (!ssv[i]) li = i;
        if ($countones(~ssv) != 1)  sel_obs = 4;
        else if (sel_obs == -1)     sel_obs = li;
        else if (sel_obs != li)     sel_obs = 4;
      end else begin
        hi_run++;
      end
      if (scl && !prev_scl) begin
        frame_obs = {frame_obs[15:0], mosi};
        rises++;
      end
      prev_scl = scl;
      // Slave: during bit k (rises == k) present data bit 16-k, MSB first.
      miso = (rises >= 9 && rises <= 16) ? slave_byte[3'(16 - rises)] : 1'b0;
    end
  end

  // -------------------------------------------------------------------
  // Monitor for dut1 (CLK_DIV=1)
  // -------------------------------------------------------------------
  logic        prev1;
  int          rises1, low1, t_gnt1, last1, per1;
  logic [16:0] frame1;

  always @(negedge clk) begin : monitor1
    logic [W-1:0] e;
    if (!rst_n) begin
      prev1 = 1'b0; rises1 = 0; low1 = 0; t_gnt1 = 0; last1 = 0; per1 = 0;
      frame1 = '0;
    end else begin
      if (bus1.done != 4'h0) begin
        if (exp1_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_done1: got done=%b with no frame expected", bus1.done);
        end else begin
          e = exp1_q.pop_front();
          check("div1_done_onehot", 32'(bus1.done), 32'(4'b0001 << e[42:41]));
          check("div1_rdata", 32'(bus1.rdata), 32'(e[40:33]));
          check("div1_mosi_frame", 32'(frame1), 32'(e[32:16]));
          check("div1_ss_low_cycles", low1, 32'(e[15:8]));
          check("div1_gnt_to_done", cyc - t_gnt1, 32'(e[7:0]));
          check("div1_scl_period", per1, 32'd2);
        end
        rises1 = 0; low1 = 0; per1 = 0; frame1 = '0;
      end
      if (bus1.gnt != 4'h0) t_gnt1 = cyc;
      if ({s1_4, s1_3, s1_2, s1_1} != 4'hF) low1++;
      if (scl1 && !prev1) begin
        frame1 = {frame1[15:0], mosi1};
        if (rises1 > 0 && (per1 == 0 || (cyc - last1) != 2)) per1 = cyc - last1;
        last1 = cyc;
        rises1++;
      end
      prev1 = scl1;
    end
  end

  // -------------------------------------------------------------------
  // Driver tasks
  // -------------------------------------------------------------------
  task automatic issue(input int lane, input bit rw, input logic [7:0] addr,
                       input logic [7:0] wdata);
    @(posedge clk); #1;
    bus.cmd_rw[lane]             = rw;
    bus.cmd_addr[lane*8 +: 8]    = addr;
    bus.cmd_wdata[lane*8 +: 8]   = wdata;
    bus.req[lane]                = 1'b1;
  endtask

  task automatic wait_gnt(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.gnt != 4'h0) begin ok = 1'b1; break; end
    end
    if (!ok) timeout(name);
  endtask

  task automatic wait_idle(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (!bus.busy && !bus1.busy) begin ok = 1'b1; break; end
    end
    if (!ok) timeout(name);
  endtask

  task automatic drop_req();
    @(posedge clk); #1;
    bus.req = 4'h0;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_scl"},   32'(scl), 32'd0);
    check({tag, "_mosi"},  32'(mosi), 32'd0);
    check({tag, "_ss"},    32'({ss4, ss3, ss2, ss1}), 32'hF);
    check({tag, "_gnt"},   32'(bus.gnt), 32'd0);
    check({tag, "_done"},  32'(bus.done), 32'd0);
    check({tag, "_busy"},  32'(bus.busy), 32'd0);
    check({tag, "_rdata"}, 32'(bus.rdata), 32'd0);
    check({tag, "_state"}, 32'(state_dbg), 32'd0);
  endtask

  // -------------------------------------------------------------------
  // Stimulus
  // -------------------------------------------------------------------
  initial begin : stimulus
    bit ok;
    logic [1:0] order [5];
    bus.req = 4'h0;  bus.cmd_rw = 4'h0;  bus.cmd_addr = '0;  bus.cmd_wdata = '0;
    bus1.req = 4'h0; bus1.cmd_rw = 4'h0; bus1.cmd_addr = '0; bus1.cmd_wdata = '0;

    repeat (3) @(posedge clk);
    #1;
    check_reset("reset");
    check("reset_dut1_state", 32'(state_dbg1), 32'd0);
    rst_n = 1'b1;

    // Write, lane 0, addr AB, data 19.
    exp_q.push_back(mk(1'b0, 2'd0, 8'h00, 17'h1AB19, 8'd72, 8'd73));
    issue(0, 1'b1, 8'hAB, 8'h19);
    wait_gnt("gnt_wr0");
    drop_req();
    wait_idle("idle_wr0");

    // Read, lane 2, addr AB, slave answers B9; cmd_wdata must not reach mosi.
    slave_byte = 8'hB9;
    exp_q.push_back(mk(1'b0, 2'd2, 8'hB9, 17'h0AB00, 8'd72, 8'd73));
    issue(2, 1'b0, 8'hAB, 8'h77);
    wait_gnt("gnt_rd2");
    drop_req();
    wait_idle("idle_rd2");

    // Reset at bit 7 of a lane-1 frame: no done, everything back to reset.
    issue(1, 1'b1, 8'h55, 8'hAA);
    wait_gnt("gnt_abort1");
    drop_req();
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk); #1;
      if (rises >= 7) begin ok = 1'b1; break; end
    end
    if (!ok) timeout("reach_bit7");
    rst_n = 1'b0;
    #1;
    check_reset("midframe_reset");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // All four requests held: RR from a reset pointer gives 0,1,2,3,0.
`ifdef SPI_ARB_FIXED_PRIO_EN
    order = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
`else
    order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
`endif
    for (int n = 0; n < 5; n++) begin
      exp_q.push_back(mk(n != 0, order[n], 8'h00,
                         {1'b1, 8'h10 + 8'(order[n]), 8'hC0 + 8'(order[n])},
                         8'd72, 8'd73));
    end
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      bus.cmd_rw[i]           = 1'b1;
      bus.cmd_addr[i*8 +: 8]  = 8'h10 + 8'(i);
      bus.cmd_wdata[i*8 +: 8] = 8'hC0 + 8'(i);
    end
    bus.req = 4'hF;
    for (int n = 0; n < 5; n++) wait_gnt("gnt_all4");
    drop_req();
    wait_idle("idle_all4");

    // Read, lane 1, addr 3C, slave answers 5A.
    slave_byte = 8'h5A;
    exp_q.push_back(mk(1'b0, 2'd1, 8'h5A, 17'h03C00, 8'd72, 8'd73));
    issue(1, 1'b0, 8'h3C, 8'hFF);
    wait_gnt("gnt_rd1");
    drop_req();
    wait_idle("idle_rd1");

    // Write, lane 3: rdata must keep 5A.
    exp_q.push_back(mk(1'b0, 2'd3, 8'h5A, 17'h1C381, 8'd72, 8'd73));
    issue(3, 1'b1, 8'hC3, 8'h81);
    wait_gnt("gnt_wr3");
    drop_req();
    wait_idle("idle_wr3");

    // CLK_DIV=1: write lane 3, addr 00, data FF.
    exp1_q.push_back(mk(1'b0, 2'd3, 8'h00, 17'h100FF, 8'd36, 8'd37));
    @(posedge clk); #1;
    bus1.cmd_rw[3]          = 1'b1;
    bus1.cmd_addr[31:24]    = 8'h00;
    bus1.cmd_wdata[31:24]   = 8'hFF;
    bus1.req[3]             = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus1.gnt != 4'h0) begin ok = 1'b1; break; end
    end
    if (!ok) timeout("gnt_div1");
    @(posedge clk); #1;
    bus1.req = 4'h0;
    wait_idle("idle_div1");

    repeat (5) @(posedge clk);
    check("pending_frames", exp_q.size(), 32'd0);
    check("pending_frames_div1", exp1_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/spi_bus_arbiter.md
Name: spi_bus_arbiter

Overview:
- Shares one SPI master bus (scl/mosi/miso) among four on-chip requesters; each requester owns one slave select (ss1..ss4, active low).
- Serialises each granted command into the codebase's 17-bit frame: 1 R/W bit (1 = write), 8 address bits, 8 data bits, all MSB first.
- Captures read data from miso and returns it to the requester.
- Sits between the system command sources and the external Slave-side SPI devices.

Parameters:
- CLK_DIV, 2, clk cycles per scl half-period; legal range 1..255.
- FRAME_BITS, 17, bits per frame; fixed at 17, not to be overridden.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  4  per-requester level request; bit i maps to ss(i+1).
- cmd_rw  input  4  per-requester R/W: 1 = write, 0 = read.
- cmd_addr  input  32  per-requester address; bits [8i+7:8i] belong to requester i.
- cmd_wdata  input  32  per-requester write data; bits [8i+7:8i] belong to requester i.
- gnt  output  4  one-hot, 1-cycle pulse when the command is latched.
- done  output  4  one-hot, 1-cycle pulse when the frame completes.
- rdata  output  8  read data; valid from the done pulse until the next done.
- busy  output  1  high from the gnt cycle through the DONE cycle.
- scl  output  1  SPI clock; idles low.
- mosi  output  1  SPI data out.
- miso  input  1  SPI data in.
- ss1, ss2, ss3, ss4  output  1 each  slave selects, active low.

Behaviour:
- Reset values (async on rst_n low, including mid-frame): scl=0, mosi=0, ss1..ss4=1, gnt=0, done=0, busy=0, rdata=0, RR pointer = 3 (requester 0 wins first). Any frame in progress is abandoned with no done pulse.
- States: IDLE, SETUP, SHIFT, HOLD, DONE.
- IDLE:
  - If any req bit is high, pick the winner round-robin, searching from last_granted+1 upward with wrap 3->0.
  - Same cycle: pulse gnt[win], latch {rw, addr, wdata} of the winner into a 17-bit shift register, set busy, go to SETUP.
- SETUP:
  - ss of the winner driven low; mosi = frame bit 16 (R/W); scl stays 0.
  - Lasts CLK_DIV cycles, then go to SHIFT.
- SHIFT:
  - 17 bit periods; each is CLK_DIV cycles scl low, then CLK_DIV cycles scl high.
  - mosi changes only at bit-period start, i.e. on scl falling edge or SETUP exit; it is stable across every rising edge.
  - On each scl rising edge for bit indices 9..16 (data phase, counting from 0) of a read frame, miso is shifted into the rdata shift register, MSB first.
  - During the data phase of a read frame, mosi = 0.
  - After the high half of bit 16: scl goes to 0, go to HOLD.
- HOLD: ss stays low for CLK_DIV cycles, scl = 0, then go to DONE.
- DONE (1 cycle):
  - ss deasserted, done[win] pulses.
  - rdata updated for reads; rdata holds its previous value for writes. busy stays high.
  - Go to IDLE. Minimum ss-high gap between frames is 1 clk cycle.
- Frame length: ss low for (36*CLK_DIV) cycles. For CLK_DIV=2: 72 cycles, gnt to done = 73 cycles.
- Counters: the half-period counter is 8 bits; the bit counter counts 0..16 and must not wrap.
- Request changes after gnt are ignored until the next IDLE evaluation. A requester still holding req after its done competes normally; it gets no priority.
- Only one ss is low at any time, never more.
- cmd_* inputs are sampled only in the gnt cycle.

Optional Feature:
- Macro: SPI_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, req[0] highest to req[3] lowest; the RR pointer is removed.
- Undefined: round-robin as specified above.
- All timing is identical in both builds.

Test Plan:
- Write, requester 0, addr 0xAB, wdata 0x19, CLK_DIV=2 -> ss1 low 72 cycles; mosi sampled at the 17 scl rises = 1_10101011_00011001; done[0] 73 cycles after gnt[0]; rdata unchanged.
- Read, requester 2, addr 0xAB, slave model returns 0xB9 -> mosi = 0_10101011_00000000; rdata = 0xB9 at done[2]; ss3 is the only select low.
- All four req held high continuously -> gnt order 0,1,2,3,0; every gap between frames is exactly 1 cycle with all ss high. With SPI_ARB_FIXED_PRIO_EN defined -> requester 0 granted every time.
- rst_n pulsed low at bit 7 of a frame -> all ss high and scl=0 immediately (asynchronously); no done pulse; the next req is served from requester 0 with a full frame.
- CLK_DIV=1, write to addr 0x00, data 0xFF -> ss low 36 cycles; scl period 2 clk cycles; rdata unchanged.
- req dropped one cycle after gnt -> frame completes and done still pulses for that requester.
